// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave between an instruction master and a data master.
//
// Purpose
//   Grants at most one master per cycle and passes its request through to the mem_* channel.
//   The slave answers in order, so each accepted address pushes its owner tag into a FIFO.
//   Each mem_data_ok pops the head tag and steers the data_ok pulse to the owning master.
//   Once a request is presented without mem_addr_ok, the grant is locked to that master
//   until its handshake completes.
//
// Ports
//   clk, reset                         single clock, synchronous active-high reset
//   inst_sram_* req/wr/size/addr/...   instruction master request channel (in)
//   inst_sram_addr_ok/data_ok/rdata    instruction master handshake and read data (out)
//   data_sram_* req/wr/size/addr/...   data master request channel (in)
//   data_sram_addr_ok/data_ok/rdata    data master handshake and read data (out)
//   mem_* req/wr/size/addr/wstrb/wdata shared slave request channel (out)
//   mem_addr_ok/data_ok/rdata          shared slave handshake and read data (in)
//
// Configuration
//   OUTSTANDING_DEPTH        accepted-but-unanswered limit; a power of two from 2 to 8
//   SRAM_ARB_DATA_PRIO_EN    when defined, DATA wins every unlocked conflict;
//                            otherwise conflicts are resolved round-robin
module sram_like_arbiter #(
  parameter int unsigned OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PtrW = $clog2(OUTSTANDING_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {SelInst = 1'b0, SelData = 1'b1} sel_e;

  sel_e                         sel;
  logic                         sel_req;
  logic                         fifo_full;
  logic                         push;
  logic                         pop;
  logic                         head_tag;

  logic                         lock_q, lock_d;
  sel_e                         lock_sel_q, lock_sel_d;
  logic [CntW-1:0]              count_q, count_d;
  logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [OUTSTANDING_DEPTH-1:0] tag_q;
`ifndef SRAM_ARB_DATA_PRIO_EN
  // Master granted at the most recent address handshake.
  sel_e                         last_q, last_d;
`endif

  // Arbitration: a lock always wins; otherwise a lone requester wins and conflicts are resolved
  // by priority or round-robin.
  always_comb begin
    sel = SelInst;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_DATA_PRIO_EN
      sel = SelData;
`else
      sel = (last_q == SelInst) ? SelData : SelInst;
`endif
    end else if (data_sram_req) begin
      sel = SelData;
    end
  end

  assign sel_req   = (sel == SelData) ? data_sram_req : inst_sram_req;
  assign fifo_full = (count_q == CntW'(OUTSTANDING_DEPTH));

  // Request fields are zero whenever the selected master is idle.
  always_comb begin
    mem_req   = sel_req && !fifo_full;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (sel_req) begin
      if (sel == SelData) begin
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_addr  = data_sram_addr;
        mem_wstrb = data_sram_wstrb;
        mem_wdata = data_sram_wdata;
      end else begin
        mem_wr    = inst_sram_wr;
        mem_size  = inst_sram_size;
        mem_addr  = inst_sram_addr;
        mem_wstrb = inst_sram_wstrb;
        mem_wdata = inst_sram_wdata;
      end
    end
  end

  assign push     = mem_req && mem_addr_ok;
  // A response that finds no outstanding tag (including during reset) is dropped.
  assign pop      = mem_data_ok && (count_q != '0) && !reset;
  assign head_tag = tag_q[rd_ptr_q];

  assign inst_sram_addr_ok = push && (sel == SelInst);
  assign data_sram_addr_ok = push && (sel == SelData);
  assign inst_sram_data_ok = pop && !head_tag;
  assign data_sram_data_ok = pop && head_tag;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_comb begin
    // A presented but unaccepted request pins the grant for the next cycle.
    lock_d     = mem_req && !mem_addr_ok;
    lock_sel_d = sel;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
`ifndef SRAM_ARB_DATA_PRIO_EN
    last_d = push ? sel : last_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_sel_q <= SelInst;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifndef SRAM_ARB_DATA_PRIO_EN
      // Last grant reads as DATA, so the first conflict goes to INST.
      last_q     <= SelData;
`endif
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifndef SRAM_ARB_DATA_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      tag_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter; expected owner tags are queued as grants are driven
// and popped as responses are returned.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_wr, i_aok, i_dok;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic [3:0]  i_wstrb;
  logic        d_req, d_wr, d_aok, d_dok;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        m_req, m_wr, m_aok, m_dok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (i_req),
    .inst_sram_wr      (i_wr),
    .inst_sram_size    (i_size),
    .inst_sram_addr    (i_addr),
    .inst_sram_wstrb   (i_wstrb),
    .inst_sram_wdata   (i_wdata),
    .inst_sram_addr_ok (i_aok),
    .inst_sram_data_ok (i_dok),
    .inst_sram_rdata   (i_rdata),
    .data_sram_req     (d_req),
    .data_sram_wr      (d_wr),
    .data_sram_size    (d_size),
    .data_sram_addr    (d_addr),
    .data_sram_wstrb   (d_wstrb),
    .data_sram_wdata   (d_wdata),
    .data_sram_addr_ok (d_aok),
    .data_sram_data_ok (d_dok),
    .data_sram_rdata   (d_rdata),
    .mem_req           (m_req),
    .mem_wr            (m_wr),
    .mem_size          (m_size),
    .mem_addr          (m_addr),
    .mem_wstrb         (m_wstrb),
    .mem_wdata         (m_wdata),
    .mem_addr_ok       (m_aok),
    .mem_data_ok       (m_dok),
    .mem_rdata         (m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Set master requests and slave responses, then let combinational outputs settle.
  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok,
                       input logic [31:0] rd);
    i_req   = ir;
    d_req   = dr;
    m_aok   = aok;
    m_dok   = dok;
    m_rdata = rd;
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Grant check for an accepted handshake by owner (0=INST, 1=DATA); queues the expected owner.
  task automatic grant(input string tag, input logic owner);
    check({tag, "_req"}, m_req, 1);
    check({tag, "_addr"}, m_addr, owner ? d_addr : i_addr);
    check({tag, "_wr"}, m_wr, owner ? d_wr : i_wr);
    check({tag, "_iaok"}, i_aok, !owner);
    check({tag, "_daok"}, d_aok, owner);
    exp_q.push_back(owner);
  endtask

  task automatic resp(input string tag, input logic [31:0] rd);
    logic owner;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, observed idok=%0b ddok=%0b", tag, i_dok, d_dok);
    end else begin
      owner = exp_q.pop_front();
      check({tag, "_idok"}, i_dok, !owner);
      check({tag, "_ddok"}, d_dok, owner);
      check({tag, "_irdata"}, i_rdata, rd);
      check({tag, "_drdata"}, d_rdata, rd);
    end
  endtask

  task automatic single(input string tag, input logic owner);
    drive(!owner, owner, 1, 0, 0);
    grant(tag, owner);
    next();
  endtask

  task automatic drain(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 1, 32'h5000 + k);
      resp(tag, 32'h5000 + k);
      next();
    end
  endtask

  initial begin
    logic exp;
    logic seq[4];

    reset = 1;
    i_wr = 0; i_size = 2'd2; i_addr = 32'h100; i_wstrb = 4'h0; i_wdata = 0;
    d_wr = 1; d_size = 2'd2; d_addr = 32'h200; d_wstrb = 4'hf; d_wdata = 32'hdead_beef;
    drive(0, 0, 0, 1, 32'h1234);
    next();
    check("rst_idok", i_dok, 0);
    check("rst_ddok", d_dok, 0);
    check("rst_mreq", m_req, 0);
    next();
    reset = 0;
    drive(0, 0, 0, 0, 0);
    check("idle_mreq", m_req, 0);
    check("idle_maddr", m_addr, 0);
    check("idle_mwr", m_wr, 0);
    check("idle_mwstrb", m_wstrb, 0);
    check("idle_iaok", i_aok, 0);
    check("idle_daok", d_aok, 0);

    // Both masters request every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0, 0);
`ifdef SRAM_ARB_DATA_PRIO_EN
      exp = 1'b1;
`else
      exp = (i % 2) != 0;
`endif
      grant("arb", exp);
      next();
    end
    drive(1, 1, 1, 0, 0);
    check("arb_full_mreq", m_req, 0);
    check("arb_full_iaok", i_aok, 0);
    check("arb_full_daok", d_aok, 0);
    drain("arb_drain", 4);

    // DATA stalls without addr_ok; INST arrives and must not preempt.
    d_addr = 32'h1000;
    drive(0, 1, 0, 0, 0);
    check("lock1_maddr", m_addr, 32'h1000);
    check("lock1_daok", d_aok, 0);
    next();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0);
      check("lock_maddr", m_addr, 32'h1000);
      check("lock_mreq", m_req, 1);
      check("lock_iaok", i_aok, 0);
      next();
    end
    drive(1, 1, 1, 0, 0);
    grant("lock_hs", 1);
    next();
    drive(1, 0, 1, 0, 0);
    grant("lock_inst", 0);
    next();
    drain("lock_drain", 2);

    // Fill, block, then drain with responses going to the recorded owners.
    seq = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) single("fill", seq[i]);
    drive(1, 0, 1, 1, 32'hA);
    check("full_dok_mreq", m_req, 0);
    check("full_dok_iaok", i_aok, 0);
    resp("fill_a", 32'hA);
    next();
    drive(0, 0, 0, 1, 32'hB); resp("fill_b", 32'hB); next();
    drive(0, 0, 0, 1, 32'hC); resp("fill_c", 32'hC); next();
    drive(0, 0, 0, 1, 32'hD); resp("fill_d", 32'hD); next();

    // Push and pop together at count 2.
    single("pp", 0);
    single("pp", 1);
    drive(1, 0, 1, 1, 32'h77);
    resp("pp_same", 32'h77);
    grant("pp_same", 0);
    next();
    drain("pp_drain", 2);
    drive(0, 0, 0, 1, 32'h88);
    check("empty_idok", i_dok, 0);
    check("empty_ddok", d_dok, 0);
    next();

    // Reset with outstanding tags abandons them.
    single("rst_out", 1);
    single("rst_out", 0);
    single("rst_out", 1);
    reset = 1;
    drive(0, 0, 0, 1, 32'h99);
    check("mid_rst_idok", i_dok, 0);
    check("mid_rst_ddok", d_dok, 0);
    next();
    reset = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 32'h99);
      check("post_rst_idok", i_dok, 0);
      check("post_rst_ddok", d_dok, 0);
      next();
    end
    single("post_rst", 0);
    drain("post_rst_drain", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter OUTSTANDING_DEPTH, default 4, SHALL set the maximum number of accepted requests not yet answered; legal values are powers of two from 2 to 8.
REQ-002 clk  in  1  single clock; every register SHALL update only on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_sram_req/wr/size/addr/wstrb/wdata  in  1/1/2/32/4/32  instruction master request channel.
REQ-005 inst_sram_addr_ok/data_ok  out  1/1; inst_sram_rdata  out  32  instruction master handshake and read data.
REQ-006 data_sram_req/wr/size/addr/wstrb/wdata  in  1/1/2/32/4/32  data master request channel.
REQ-007 data_sram_addr_ok/data_ok  out  1/1; data_sram_rdata  out  32  data master handshake and read data.
REQ-008 mem_req/wr/size/addr/wstrb/wdata  out  1/1/2/32/4/32  shared slave request channel.
REQ-009 mem_addr_ok/data_ok  in  1/1; mem_rdata  in  32  shared slave handshake and read data.

Function
REQ-010 The block SHALL select at most one master per cycle (sel = INST or DATA) and drive that master's req/wr/size/addr/wstrb/wdata on the mem_* outputs combinationally.
REQ-011 mem_req SHALL equal sel-master req AND NOT fifo_full; when neither master requests, mem_req SHALL be 0 and mem_wr/size/addr/wstrb/wdata SHALL be 0.
REQ-012 Lock: if mem_req=1 and mem_addr_ok=0, sel SHALL be held, via a lock register, until the cycle mem_req and mem_addr_ok are both 1; a competing request SHALL NOT preempt a locked master.
REQ-013 Master addr_ok SHALL equal mem_addr_ok AND mem_req AND (sel is that master); the non-selected master's addr_ok SHALL be 0.
REQ-014 Each address handshake (mem_req and mem_addr_ok) SHALL push the owner tag (0=INST, 1=DATA) into an in-order tag FIFO of OUTSTANDING_DEPTH entries.
REQ-015 Each mem_data_ok SHALL pop the head tag and pulse data_ok only to the owning master in the same cycle, with no added latency. Reads and writes both produce exactly one data_ok.
REQ-016 mem_rdata SHALL be driven unmodified onto both inst_sram_rdata and data_sram_rdata; only the data_ok pulses are routed by owner.
REQ-017 FIFO full (count = OUTSTANDING_DEPTH): mem_req and both addr_ok outputs SHALL be 0. A data_ok in the same cycle SHALL NOT unblock a grant in that cycle.
REQ-018 A push and a pop in the same cycle SHALL leave the count unchanged. Pointers SHALL wrap modulo OUTSTANDING_DEPTH.
REQ-019 mem_data_ok while the FIFO is empty SHALL be ignored: no pop, no master data_ok.
REQ-020 A new request SHALL be grantable in the same cycle that an older response returns.

Reset
REQ-021 On reset the FIFO count, both pointers and the lock register SHALL clear, and the round-robin pointer SHALL favour INST.
REQ-022 While reset is high and in the first cycle after it, all outputs SHALL be 0 unless a master requests; any outstanding responses arriving after reset SHALL be discarded as in REQ-019.
REQ-023 Reset asserted mid-transaction SHALL abandon all outstanding tags without emitting data_ok.

Configuration
REQ-024 With macro SRAM_ARB_DATA_PRIO_EN defined, an unlocked arbitration SHALL select DATA whenever data_sram_req=1, otherwise INST.
REQ-025 With SRAM_ARB_DATA_PRIO_EN undefined, arbitration SHALL be round-robin:
- on conflict, sel = the master not granted at the last address handshake;
- the round-robin pointer SHALL update only on handshake.

Verification
REQ-026 Both reqs=1 every cycle, mem_addr_ok=1, prio macro defined -> DATA granted every cycle and INST starves; macro undefined -> grants alternate INST, DATA, INST, DATA.
REQ-027 DATA req at 0x1000 with mem_addr_ok=0 for 3 cycles, INST req asserted in cycle 2 -> sel stays DATA, mem_addr stays 0x1000, and INST addr_ok stays 0 until DATA's handshake.
REQ-028 Accept 4 requests (INST, DATA, DATA, INST) with no data_ok -> 5th request blocked (mem_req=0). Then 4 mem_data_ok with rdata 0xA,0xB,0xC,0xD -> data_ok pulses go to inst, data, data, inst respectively.
REQ-029 Count=2, handshake and mem_data_ok in the same cycle -> count stays 2 and the head owner receives data_ok.
REQ-030 Reset with 3 outstanding, then mem_data_ok pulses -> no master data_ok, and the first post-reset request is granted normally.
